// File: rtl/bu_fetch_if.sv
// Fetch-queue bus bundle: instruction-memory port, redirect input and ID-side handshake.
interface bu_fetch_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
);
    logic                       fetch_en;
    logic                       imem_req;
    logic [ADDR_W-1:0]          imem_addr;
    logic [DATA_W-1:0]          imem_data;
    logic                       redirect_valid;
    logic [ADDR_W-1:0]          redirect_pc;
    logic                       id_valid;
    logic                       id_ready;
    logic [DATA_W-1:0]          id_instr;
    logic [ADDR_W-1:0]          id_pc;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        input  fetch_en, imem_data, redirect_valid, redirect_pc, id_ready,
        output imem_req, imem_addr, id_valid, id_instr, id_pc, count
    );

    modport slave (
        output fetch_en, imem_data, redirect_valid, redirect_pc, id_ready,
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, count
    );
endinterface

// File: rtl/bu_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency imem requests
// and buffers {pc, instr} pairs in a show-ahead FIFO drained by ID.
module bu_fetch_queue #(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 12,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = 1
) (
    input  logic      clk,
    input  logic      rst,
    bu_fetch_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    entry_t             mem [DEPTH];
    logic               run;
    logic               inflight;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W:0]     credits_used;
    logic               nonempty;
    logic               issue;
    logic               push;
    logic               pop;

    // Credits come from registered state only, so an outstanding request always has a slot.
    assign credits_used = {1'b0, cnt} + {{CNT_W{1'b0}}, inflight};
    assign nonempty     = (cnt != '0);
    assign issue        = run & bus.fetch_en & ~bus.redirect_valid
                        & (credits_used < (CNT_W+1)'(DEPTH));
    assign push         = inflight & ~bus.redirect_valid;
    assign pop          = nonempty & bus.id_ready & ~bus.redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run         <= 1'b0;
            inflight    <= 1'b0;
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            cnt         <= '0;
        end else begin
            run <= 1'b1;
            if (bus.redirect_valid) begin
                // The response to any request issued last cycle arrives next cycle and is dropped.
                inflight <= 1'b0;
                fetch_pc <= bus.redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                cnt      <= '0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    fetch_pc    <= fetch_pc + PC_STEP;
                    inflight_pc <= fetch_pc;
                end
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    // Storage needs no reset: contents are only visible while cnt says they are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pc: inflight_pc, instr: bus.imem_data};
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.id_valid  = nonempty;
    assign bus.id_instr  = nonempty ? mem[rd_ptr].instr : '0;
    assign bus.id_pc     = nonempty ? mem[rd_ptr].pc    : '0;
    assign bus.count     = cnt;
endmodule

// File: tb/tb_bu_fetch_queue.sv
// Randomized bench for bu_fetch_queue against a queue-based transaction model.
module tb_bu_fetch_queue;
    localparam int         DW    = 16;
    localparam int         AW    = 12;
    localparam int         DEPTH = 4;
    localparam logic [11:0] RPC  = 12'hFFE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bu_fetch_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) bus();

    bu_fetch_queue #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(RPC), .PC_STEP(12'd1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_f(input logic [11:0] a);
        return 16'h1000 + {4'h0, a};
    endfunction

    // Reference model: occupancy is just the length of a queue of {pc, instr}.
    bit          m_run;
    bit          m_infl;
    logic [11:0] m_pc;
    logic [11:0] m_ipc;
    logic [27:0] m_q[$];
    bit          last_req;
    logic [11:0] last_addr;

    task automatic model_reset();
        m_run  = 1'b0;
        m_infl = 1'b0;
        m_pc   = RPC;
        m_q.delete();
    endtask

    task automatic step(input bit fe, input bit rv, input logic [11:0] rp,
                        input bit rdy, input bit do_rst);
        bit exp_req;
        @(negedge clk);
        rst                = do_rst;
        bus.fetch_en       = fe;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.id_ready       = rdy;
        // Memory answers whatever the DUT actually asked for last cycle.
        bus.imem_data      = last_req ? mem_f(last_addr) : 16'($urandom);
        if (do_rst) model_reset();
        #1;
        exp_req = !do_rst && m_run && fe && !rv && ((m_q.size() + int'(m_infl)) < DEPTH);
        chk("imem_req",  32'(bus.imem_req),  32'(exp_req));
        chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
        chk("id_valid",  32'(bus.id_valid),  32'(m_q.size() != 0));
        chk("id_pc",     32'(bus.id_pc),     (m_q.size() != 0) ? 32'(m_q[0][27:16]) : 32'd0);
        chk("id_instr",  32'(bus.id_instr),  (m_q.size() != 0) ? 32'(m_q[0][15:0])  : 32'd0);
        chk("count",     32'(bus.count),     32'(m_q.size()));
        last_req  = bus.imem_req;
        last_addr = bus.imem_addr;
        if (!do_rst) begin
            if (rv) begin
                m_q.delete();
                m_infl = 1'b0;
                m_pc   = rp;
            end else begin
                if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
                if (m_infl) m_q.push_back({m_ipc, mem_f(m_ipc)});
                if (exp_req) begin
                    m_ipc = m_pc;
                    m_pc  = m_pc + 12'd1;
                end
                m_infl = exp_req;
            end
            m_run = 1'b1;
        end
    endtask

    initial begin
        bus.fetch_en       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;
        bus.imem_data      = '0;
        last_req           = 1'b0;
        last_addr          = '0;
        model_reset();

        repeat (3) step(1, 0, 12'h0, 1, 1);
        // Streaming with ID always ready: PC wraps FFE,FFF,000,... and FIFO pointers wrap.
        repeat (20) step(1, 0, 12'h0, 1, 0);
        // ID stalled: FIFO saturates and requests stop.
        repeat (10) step(1, 0, 12'h0, 0, 0);
        // Single-cycle pop from full, then stall again.
        step(1, 0, 12'h0, 1, 0);
        repeat (4) step(1, 0, 12'h0, 0, 0);
        repeat (8) step(1, 0, 12'h0, 1, 0);
        // Fill partially, then redirect with a request in flight.
        repeat (2) step(1, 0, 12'h0, 0, 0);
        step(1, 1, 12'h0A0, 0, 0);
        repeat (6) step(1, 0, 12'h0, 1, 0);
        // Back-to-back redirects: the last one wins.
        step(1, 1, 12'h123, 1, 0);
        step(1, 1, 12'h456, 1, 0);
        repeat (6) step(1, 0, 12'h0, 1, 0);
        // fetch_en low: outstanding response still lands and FIFO drains.
        repeat (6) step(0, 0, 12'h0, 1, 0);
        // Reset pulse mid-stream.
        repeat (5) step(1, 0, 12'h0, 0, 0);
        step(1, 0, 12'h0, 0, 1);
        repeat (8) step(1, 0, 12'h0, 1, 0);

        for (int i = 0; i < 2000; i++) begin
            bit          fe, rv, rdy, rs;
            logic [11:0] rp;
            fe  = ($urandom_range(7) != 0);
            rdy = (i % 400 < 200) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            rv  = ($urandom_range(19) == 0);
            rp  = ($urandom_range(1) != 0) ? 12'(12'hFFC + $urandom_range(3)) : 12'($urandom);
            rs  = ($urandom_range(249) == 0);
            step(fe, rv, rp, rdy, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
